// File: rtl/mem_stage_fsm_if.sv
// Memory Controller (MC) request/complete channel between the MEM stage and the MC.
//   master (MEM side) drives: MCE_out, MCrw_out, MCAddr_out, MCData_out, MCLen_out,
//                             MEM_MCAccess_out
//   slave  (MC side)  drives: MC_busy_in, MC_dataE_in, MC_data_in
interface mem_mc_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  MCE_out;
  logic                  MCrw_out;
  logic [ADDR_WIDTH-1:0] MCAddr_out;
  logic [DATA_WIDTH-1:0] MCData_out;
  logic [2:0]            MCLen_out;
  logic                  MEM_MCAccess_out;
  logic                  MC_busy_in;
  logic                  MC_dataE_in;
  logic [DATA_WIDTH-1:0] MC_data_in;

  modport master (
    output MCE_out, MCrw_out, MCAddr_out, MCData_out, MCLen_out, MEM_MCAccess_out,
    input  MC_busy_in, MC_dataE_in, MC_data_in
  );

  modport slave (
    input  MCE_out, MCrw_out, MCAddr_out, MCData_out, MCLen_out, MEM_MCAccess_out,
    output MC_busy_in, MC_dataE_in, MC_data_in
  );
endinterface

// File: rtl/mem_stage_fsm.sv
// MEM pipeline stage: issues loads/stores to the MC, stalls while an access is in
// flight, extends load data, and passes non-memory instructions straight through.
// Ports:
//   clk_in, rst_in      clock, asynchronous active-high reset
//   *_in (EX_MEM side)  instruction tag, memory op, address, store data, rd fields
//   mc                  MC channel (master modport), request fields are registered
//   *_out (MEM_WB side) tag, rd fields (combinational), fault pulse, stall request
module mem_stage_fsm #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned REG_IDX_WIDTH    = 5,
  parameter int unsigned INST_IDX_WIDTH   = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [INST_IDX_WIDTH-1:0] instIdx_in,
  input  logic [3:0]                memOp_in,
  input  logic [ADDR_WIDTH-1:0]     memAddr_in,
  input  logic [DATA_WIDTH-1:0]     valStore_in,
  input  logic                      rdE_in,
  input  logic [REG_IDX_WIDTH-1:0]  rdIdx_in,
  input  logic [DATA_WIDTH-1:0]     rdData_in,
  mem_mc_if.master                  mc,
  output logic [INST_IDX_WIDTH-1:0] instIdx_out,
  output logic                      rdE_out,
  output logic [REG_IDX_WIDTH-1:0]  rdIdx_out,
  output logic [DATA_WIDTH-1:0]     rdData_out,
  output logic                      memFault_out,
  output logic                      memStall_out
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

  state_t                  state_q, state_d;
  logic                    mce_q, mce_d;
  logic                    rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [2:0]              len_q, len_d;
  logic                    access_q, access_d;
  logic                    fault_q, fault_d;
  logic [DATA_WIDTH-1:0]   load_q, load_d;
  logic [3:0]              op_q, op_d;

  logic                    is_load, is_store, is_mem, misaligned, op_q_is_load;
  logic [2:0]              req_len;
  logic [DATA_WIDTH-1:0]   store_data, load_ext;

  // Decode of the incoming op: class, byte length, alignment, masked store data.
  always_comb begin
    is_load  = memOp_in inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    is_store = memOp_in inside {OP_SB, OP_SH, OP_SW};
    is_mem   = is_load | is_store;
    case (memOp_in)
      OP_LB, OP_LBU, OP_SB: req_len = 3'd1;
      OP_LH, OP_LHU, OP_SH: req_len = 3'd2;
      default:              req_len = 3'd4;
    endcase
    misaligned = ((req_len == 3'd2) && memAddr_in[0]) ||
                 ((req_len == 3'd4) && (memAddr_in[1:0] != 2'b00));
    store_data = '0;
    case (req_len)
      3'd1:    store_data[7:0]  = valStore_in[7:0];
      3'd2:    store_data[15:0] = valStore_in[15:0];
      default: store_data[31:0] = valStore_in[31:0];
    endcase
  end

  // Extension of the captured load word according to the op latched at issue.
  always_comb begin
    op_q_is_load = op_q inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    case (op_q)
      OP_LB:   load_ext = DATA_WIDTH'($signed(load_q[7:0]));
      OP_LH:   load_ext = DATA_WIDTH'($signed(load_q[15:0]));
      OP_LBU:  load_ext = DATA_WIDTH'(load_q[7:0]);
      OP_LHU:  load_ext = DATA_WIDTH'(load_q[15:0]);
      default: load_ext = DATA_WIDTH'($signed(load_q[31:0]));
    endcase
  end

  // State and registered MC request fields.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      mce_q    <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      len_q    <= 3'd0;
      access_q <= 1'b0;
      fault_q  <= 1'b0;
      load_q   <= '0;
      op_q     <= 4'd0;
    end else begin
      state_q  <= state_d;
      mce_q    <= mce_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      len_q    <= len_d;
      access_q <= access_d;
      fault_q  <= fault_d;
      load_q   <= load_d;
      op_q     <= op_d;
    end
  end

  // Next state, next request fields and the combinational MEM_WB outputs.
  always_comb begin
    state_d      = state_q;
    mce_d        = mce_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    data_d       = data_q;
    len_d        = len_q;
    access_d     = access_q;
    fault_d      = 1'b0;
    load_d       = load_q;
    op_d         = op_q;
    instIdx_out  = instIdx_in;
    rdE_out      = rdE_in;
    rdIdx_out    = rdIdx_in;
    rdData_out   = rdData_in;
    memStall_out = 1'b0;

    case (state_q)
      IDLE: begin
        if (is_mem) begin
          memStall_out = 1'b1;
          rdE_out      = 1'b0;
          if (misaligned && !ALLOW_MISALIGNED) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else if (!mc.MC_busy_in) begin
            state_d  = REQ;
            mce_d    = 1'b1;
            access_d = 1'b1;
            rw_d     = is_store;
            addr_d   = memAddr_in;
            data_d   = is_store ? store_data : '0;
            len_d    = req_len;
            op_d     = memOp_in;
          end
        end
      end
      REQ: begin
        memStall_out = 1'b1;
        rdE_out      = 1'b0;
        if (mc.MC_dataE_in) begin
          state_d  = DONE;
          load_d   = mc.MC_data_in;
          mce_d    = 1'b0;
          access_d = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        rdE_out = op_q_is_load ? rdE_in : 1'b0;
        if (op_q_is_load) rdData_out = load_ext;
      end
      FAULT: begin
        state_d = IDLE;
        rdE_out = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Reset forces the pass-through path quiet as well.
    if (rst_in) begin
      instIdx_out  = '0;
      rdE_out      = 1'b0;
      rdIdx_out    = '0;
      rdData_out   = '0;
      memStall_out = 1'b0;
    end
  end

  assign mc.MCE_out          = mce_q;
  assign mc.MCrw_out         = rw_q;
  assign mc.MCAddr_out       = addr_q;
  assign mc.MCData_out       = data_q;
  assign mc.MCLen_out        = len_q;
  assign mc.MEM_MCAccess_out = access_q;
  assign memFault_out        = fault_q;

endmodule

// File: tb/tb_mem_stage_fsm.sv
// Bench for mem_stage_fsm: directed scenarios plus randomized ops, each checked
// cycle by cycle against a transaction-level timeline computed from the op's
// busy wait and MC response latency.
module tb_mem_stage_fsm;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned IW = 32;

  logic          clk, rst;
  logic [IW-1:0] inst_idx;
  logic [3:0]    mem_op, b_op;
  logic [AW-1:0] mem_addr, b_addr;
  logic [DW-1:0] val_store, rd_data;
  logic          rd_e;
  logic [RW-1:0] rd_idx;

  logic [IW-1:0] a_inst, b_inst;
  logic          a_rde, b_rde, a_fault, b_fault, a_stall, b_stall;
  logic [RW-1:0] a_idx, b_idx;
  logic [DW-1:0] a_data, b_data;

  int total = 0;
  int bad   = 0;

  mem_mc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mc_a ();
  mem_mc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mc_b ();

  mem_stage_fsm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_IDX_WIDTH(RW),
                  .INST_IDX_WIDTH(IW), .ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk_in(clk), .rst_in(rst), .instIdx_in(inst_idx), .memOp_in(mem_op),
    .memAddr_in(mem_addr), .valStore_in(val_store), .rdE_in(rd_e), .rdIdx_in(rd_idx),
    .rdData_in(rd_data), .mc(mc_a), .instIdx_out(a_inst), .rdE_out(a_rde),
    .rdIdx_out(a_idx), .rdData_out(a_data), .memFault_out(a_fault), .memStall_out(a_stall)
  );

  mem_stage_fsm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_IDX_WIDTH(RW),
                  .INST_IDX_WIDTH(IW), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk_in(clk), .rst_in(rst), .instIdx_in(inst_idx), .memOp_in(b_op),
    .memAddr_in(b_addr), .valStore_in(val_store), .rdE_in(rd_e), .rdIdx_in(rd_idx),
    .rdData_in(rd_data), .mc(mc_b), .instIdx_out(b_inst), .rdE_out(b_rde),
    .rdIdx_out(b_idx), .rdData_out(b_data), .memFault_out(b_fault), .memStall_out(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned op_len(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      default:          return 4;
    endcase
  endfunction

  // Value written back for a load: low bytes of the MC word, sign- or zero-filled.
  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] raw);
    int unsigned bytes;
    logic [31:0] mask, v;
    bit sgn;
    bytes = op_len(op);
    sgn   = (op == 4'd1) || (op == 4'd2) || (op == 4'd3);
    mask  = (bytes == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * bytes)) - 64'd1);
    v     = raw & mask;
    if (sgn && (v > (mask >> 1))) v = v | ~mask;
    return v;
  endfunction

  task automatic run_nop(input logic [3:0] op, input logic e, input logic [RW-1:0] idx,
                         input logic [DW-1:0] dat);
    mem_op = op; rd_e = e; rd_idx = idx; rd_data = dat; inst_idx = $urandom;
    mc_a.MC_busy_in  = 1'($urandom_range(0, 1));
    mc_a.MC_dataE_in = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("nop_rde",   64'(a_rde),   64'(e));
    chk("nop_idx",   64'(a_idx),   64'(idx));
    chk("nop_data",  64'(a_data),  64'(dat));
    chk("nop_inst",  64'(a_inst),  64'(inst_idx));
    chk("nop_stall", 64'(a_stall), 64'd0);
    chk("nop_mce",   64'(mc_a.MCE_out), 64'd0);
    @(posedge clk); #1;
    mc_a.MC_busy_in = 1'b0; mc_a.MC_dataE_in = 1'b0;
  endtask

  // One memory op on dut_a: MC busy for b cycles, completion k cycles into the request.
  task automatic run_op(input logic [3:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] sv, input int b, input int k,
                        input logic [DW-1:0] d);
    bit ld;
    bit exp_mce;
    int unsigned len;
    logic [63:0] sdata;
    inst_idx = $urandom; rd_e = 1'($urandom); rd_idx = RW'($urandom); rd_data = $urandom;
    mem_op = op; mem_addr = addr; val_store = sv;
    ld    = (op >= 4'd1) && (op <= 4'd5);
    len   = op_len(op);
    sdata = {32'd0, sv} & ((64'd1 << (8 * len)) - 64'd1);
    for (int c = 0; c <= b + k + 1; c++) begin
      mc_a.MC_busy_in  = (c < b) ? 1'b1 : ((c > b) ? 1'($urandom_range(0, 1)) : 1'b0);
      mc_a.MC_dataE_in = (c == b + k) ? 1'b1 :
                         ((c <= b || c == b + k + 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      mc_a.MC_data_in  = (c == b + k) ? d : $urandom;
      @(negedge clk);
      exp_mce = (c > b) && (c <= b + k);
      chk("stall",  64'(a_stall), 64'(c <= b + k));
      chk("mce",    64'(mc_a.MCE_out), 64'(exp_mce));
      chk("access", 64'(mc_a.MEM_MCAccess_out), 64'(exp_mce));
      chk("fault",  64'(a_fault), 64'd0);
      chk("inst",   64'(a_inst), 64'(inst_idx));
      chk("rdidx",  64'(a_idx), 64'(rd_idx));
      if (exp_mce) begin
        chk("mc_rw",   64'(mc_a.MCrw_out), 64'(!ld));
        chk("mc_addr", 64'(mc_a.MCAddr_out), 64'(addr));
        chk("mc_len",  64'(mc_a.MCLen_out), 64'(len));
        if (!ld) chk("mc_data", 64'(mc_a.MCData_out), sdata);
      end
      if (c == b + k + 1) begin
        chk("done_rde", 64'(a_rde), 64'(ld ? rd_e : 1'b0));
        if (ld) chk("load_data", 64'(a_data), 64'(exp_load(op, d)));
      end else begin
        chk("busy_rde", 64'(a_rde), 64'd0);
      end
      @(posedge clk); #1;
    end
    mem_op = 4'd0; mc_a.MC_busy_in = 1'b0; mc_a.MC_dataE_in = 1'b0;
  endtask

  // Misaligned op on dut_b (misaligned accesses fault there).
  task automatic run_fault(input logic [3:0] op, input logic [AW-1:0] addr);
    rd_e = 1'b1; b_op = op; b_addr = addr;
    @(negedge clk);
    chk("f0_stall", 64'(b_stall), 64'd1);
    chk("f0_rde",   64'(b_rde), 64'd0);
    chk("f0_fault", 64'(b_fault), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("f1_fault", 64'(b_fault), 64'd1);
    chk("f1_stall", 64'(b_stall), 64'd0);
    chk("f1_rde",   64'(b_rde), 64'd0);
    chk("f1_mce",   64'(mc_b.MCE_out), 64'd0);
    @(posedge clk); #1;
    b_op = 4'd0;
    @(negedge clk);
    chk("f2_fault", 64'(b_fault), 64'd0);
    chk("f2_mce",   64'(mc_b.MCE_out), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0]    rop;
    logic [AW-1:0] raddr;

    rst = 1'b1;
    mem_op = 4'd3; mem_addr = 32'h40; val_store = 32'h1; b_op = 4'd0; b_addr = '0;
    inst_idx = 32'hCAFE; rd_e = 1'b1; rd_idx = 5'd9; rd_data = 32'h55;
    mc_a.MC_busy_in = 1'b0; mc_a.MC_dataE_in = 1'b0; mc_a.MC_data_in = '0;
    mc_b.MC_busy_in = 1'b0; mc_b.MC_dataE_in = 1'b0; mc_b.MC_data_in = '0;
    #2;
    chk("rst_mce",    64'(mc_a.MCE_out), 64'd0);
    chk("rst_rw",     64'(mc_a.MCrw_out), 64'd0);
    chk("rst_addr",   64'(mc_a.MCAddr_out), 64'd0);
    chk("rst_data",   64'(mc_a.MCData_out), 64'd0);
    chk("rst_len",    64'(mc_a.MCLen_out), 64'd0);
    chk("rst_access", 64'(mc_a.MEM_MCAccess_out), 64'd0);
    chk("rst_fault",  64'(a_fault), 64'd0);
    chk("rst_rde",    64'(a_rde), 64'd0);
    chk("rst_idx",    64'(a_idx), 64'd0);
    chk("rst_rddata", 64'(a_data), 64'd0);
    chk("rst_inst",   64'(a_inst), 64'd0);
    chk("rst_stall",  64'(a_stall), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    mem_op = 4'd0; rst = 1'b0;

    // Directed scenarios.
    run_nop(4'd0, 1'b1, 5'd5, 32'h1234);
    run_nop(4'd12, 1'b1, 5'd17, 32'hA5A5_0001);
    run_op(4'd1, 32'h100, 32'h0, 0, 2, 32'h80);
    run_op(4'd4, 32'h100, 32'h0, 0, 2, 32'h80);
    run_op(4'd7, 32'h202, 32'hDEAD_BEEF, 0, 1, 32'h0);
    run_op(4'd3, 32'h300, 32'h0, 3, 2, 32'h8765_4321);
    run_op(4'd3, 32'h101, 32'h0, 0, 1, 32'h1357_9BDF);
    run_op(4'd2, 32'h20, 32'h0, 1, 3, 32'h0001_7FFF);
    run_op(4'd5, 32'h22, 32'h0, 0, 1, 32'hFFFF_9001);
    run_op(4'd6, 32'h33, 32'h1234_56F0, 2, 1, 32'h0);
    run_op(4'd8, 32'h44, 32'hF00D_CAFE, 0, 4, 32'h0);
    run_fault(4'd3, 32'h101);
    run_fault(4'd7, 32'h203);
    run_fault(4'd2, 32'h11);

    // Reset while a request is outstanding.
    mem_op = 4'd3; mem_addr = 32'h400; rd_e = 1'b1; rd_idx = 5'd7; rd_data = 32'h77;
    mc_a.MC_busy_in = 1'b0; mc_a.MC_dataE_in = 1'b0;
    @(negedge clk);
    chk("pre_stall", 64'(a_stall), 64'd1);
    @(posedge clk); #1;
    chk("req_mce", 64'(mc_a.MCE_out), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_mce",    64'(mc_a.MCE_out), 64'd0);
    chk("mid_rst_access", 64'(mc_a.MEM_MCAccess_out), 64'd0);
    chk("mid_rst_stall",  64'(a_stall), 64'd0);
    chk("mid_rst_rde",    64'(a_rde), 64'd0);
    mem_op = 4'd0;
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    run_op(4'd3, 32'h400, 32'h0, 0, 1, 32'h7654_3210);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        run_nop(($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15)),
                1'($urandom), RW'($urandom), $urandom);
      run_op(4'($urandom_range(1, 8)), $urandom, $urandom, int'($urandom_range(0, 3)),
             int'($urandom_range(1, 4)), $urandom);
    end
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 4))
        0: rop = 4'd2;
        1: rop = 4'd3;
        2: rop = 4'd5;
        3: rop = 4'd7;
        default: rop = 4'd8;
      endcase
      raddr = $urandom;
      if (op_len(rop) == 2) raddr[0] = 1'b1;
      else raddr[1:0] = 2'($urandom_range(1, 3));
      run_fault(rop, raddr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage_fsm.md
Name: mem_stage_fsm

Overview:
- Next-generation MEM pipeline stage. Executes RV32/RV64-style loads and stores through the Memory Controller (MC) using a request/complete handshake.
- Stalls the pipeline while an access is in flight and sign- or zero-extends load data.
- Non-memory instructions pass through combinationally with zero added latency.
- Sits between EX_MEM and MEM_WB, and arbitrates MC use against IF via MEM_MCAccess_out / MC_busy_in.

Parameters:
- DATA_WIDTH, 32, register/data width; must be 32 or 64.
- ADDR_WIDTH, 32, memory address width.
- REG_IDX_WIDTH, 5, register index width.
- INST_IDX_WIDTH, 32, instruction tag width; tag is passed through only.
- ALLOW_MISALIGNED, 1, if 0 then a misaligned H/W access raises a fault instead of issuing to MC.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous active-high reset
- instIdx_in  input  INST_IDX_WIDTH  instruction tag from EX_MEM
- memOp_in  input  4  0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; other codes are NOP
- memAddr_in  input  ADDR_WIDTH  effective address
- valStore_in  input  DATA_WIDTH  store data (low bytes are used)
- rdE_in  input  1  writeback enable
- rdIdx_in  input  REG_IDX_WIDTH  destination register
- rdData_in  input  DATA_WIDTH  ALU result
- MC_busy_in  input  1  MC is serving another requester
- MC_dataE_in  input  1  one-cycle completion pulse
- MC_data_in  input  DATA_WIDTH  load data, right-aligned, valid with MC_dataE_in
- MCE_out  output  1  request valid (registered)
- MCrw_out  output  1  0 READ, 1 WRITE (registered)
- MCAddr_out  output  ADDR_WIDTH  request address (registered)
- MCData_out  output  DATA_WIDTH  store data, right-aligned (registered)
- MCLen_out  output  3  byte length: 1, 2 or 4 (registered)
- MEM_MCAccess_out  output  1  MEM owns MC; high in REQ
- instIdx_out  output  INST_IDX_WIDTH  tag to MEM_WB
- rdE_out  output  1  writeback enable to MEM_WB
- rdIdx_out  output  REG_IDX_WIDTH  destination register to MEM_WB
- rdData_out  output  DATA_WIDTH  writeback data to MEM_WB
- memFault_out  output  1  misalignment fault, one-cycle pulse
- memStall_out  output  1  stall request to pipeline control

Behaviour:
- Reset (async, rst_in=1): state=IDLE. MCE_out=0, MCrw_out=0, MCAddr_out=0, MCData_out=0, MCLen_out=0, MEM_MCAccess_out=0, memFault_out=0, internal load register=0.
- During reset the combinational outputs are: rdE_out=0, rdIdx_out=0, rdData_out=0, instIdx_out=0, memStall_out=0.
- Reset mid-access abandons the access. MCE_out drops immediately (asynchronously).
- EX_MEM holds its inputs stable while memStall_out=1.
- States:
  - IDLE:
    - NOP: outputs = inputs, stall=0, stays in IDLE.
    - Memory op: stall=1, rdE_out=0.
    - If misaligned (H with addr[0]=1; W with addr[1:0]≠0) and ALLOW_MISALIGNED=0: go to FAULT.
    - Else if MC_busy_in=0: register the request and go to REQ.
    - Else stay in IDLE.
  - REQ:
    - MCE_out=1, MEM_MCAccess_out=1, stall=1, rdE_out=0.
    - Request fields stay constant.
    - On MC_dataE_in: capture MC_data_in, drop MCE_out, go to DONE.
  - DONE (exactly 1 cycle):
    - stall=0, rdE_out=rdE_in for loads and 0 for stores.
    - rdData_out = extended load data: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW sign-extends bit 31 to DATA_WIDTH.
    - Next state IDLE. The new EX_MEM contents are evaluated in IDLE, so no instruction is issued twice.
  - FAULT (1 cycle): memFault_out=1, stall=0, rdE_out=0, no MC access, then IDLE.
- MC_dataE_in outside REQ is ignored.
- MC_busy_in is only sampled in IDLE; it does not abort REQ.
- Latency: memory op, MC idle, MC responds k≥1 cycles after MCE rises → memStall_out is high for k+1 cycles and result is presented in cycle k+1 (op arrives in cycle 0).
- Back-to-back memory ops: each one passes through IDLE, giving at least 1 stall cycle between MC requests.
- Stores: MCData_out = valStore_in masked to MCLen_out bytes; upper bits are 0.

Test Plan:
- NOP, rdE_in=1, rdIdx_in=5, rdData_in=0x1234 → same values on outputs in the same cycle, memStall_out=0, MCE_out never rises.
- LB addr 0x100, MC returns 0x80 two cycles after MCE → MCLen_out=1, MCrw_out=0, stall high 3 cycles, rdData_out=0xFFFFFF80; LBU of the same byte → 0x00000080.
- SH addr 0x202, valStore_in=0xDEADBEEF → MCrw_out=1, MCLen_out=2, MCData_out=0x0000BEEF, rdE_out=0 in DONE.
- LW with MC_busy_in=1 for 3 cycles → MCE_out stays 0 until the cycle after busy drops; stall covers the whole wait.
- ALLOW_MISALIGNED=0, LW addr 0x101 → memFault_out pulses 1 cycle, no MCE_out, rdE_out=0; with ALLOW_MISALIGNED=1 the access issues normally.
- rst_in asserted while in REQ → MCE_out, MEM_MCAccess_out and memStall_out go to 0 immediately; after release, the next LW completes normally.
